// File: rtl/inst_rom_resp.sv
// Instruction-fetch responder: word-addressed program memory with programmable wait states.
// Optional one-entry last-fetch bypass enabled by defining INST_ROM_HIT_BYPASS_EN.
module inst_rom_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [31:0]       addr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ready_o,
  output logic              err_o,
  output logic              busy_o,
  input  logic              load_we_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [DATA_W-1:0] load_data_i,
  output logic [1:0]        state_dbg
);

  // Handshake: a request is taken in IDLE when ce_i=1 and load_we_i=0; ce_i must stay
  // high until ready_o pulses (dropping it during WAIT abandons the fetch silently).

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state;
  logic [31:0]       req_addr;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [31:0]       resp_addr;
  logic [ADDR_W-1:0] resp_idx;
  logic              resp_bad;
  logic [DATA_W-1:0] resp_word;
  logic              accept;
  logic              hit;
  logic              enter_resp;

  assign state_dbg = state;

  // In IDLE the live address feeds the zero-wait and bypass paths; later the latched one.
  always_comb begin
    resp_addr  = (state == S_IDLE) ? addr_i : req_addr;
    resp_idx   = resp_addr[ADDR_W+1:2];
    resp_bad   = (resp_addr[1:0] != 2'b00) || ((resp_addr >> (ADDR_W + 2)) != 32'd0);
    resp_word  = mem[resp_idx];
    accept     = (state == S_IDLE) && ce_i && !load_we_i;
    enter_resp = (accept && !hit && (WAIT_CYCLES == 0)) ||
                 ((state == S_WAIT) && ce_i && (cnt <= 4'd1));
  end

`ifdef INST_ROM_HIT_BYPASS_EN
  logic              hit_valid;
  logic [ADDR_W-1:0] hit_idx;
  logic [DATA_W-1:0] hit_data;

  assign hit = hit_valid && !resp_bad && (resp_idx == hit_idx);
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (load_we_i) mem[load_addr_i] <= load_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      data_o   <= '0;
      ready_o  <= 1'b0;
      err_o    <= 1'b0;
      busy_o   <= 1'b0;
      cnt      <= 4'd0;
      req_addr <= 32'd0;
`ifdef INST_ROM_HIT_BYPASS_EN
      hit_valid <= 1'b0;
`endif
    end else begin
      ready_o <= 1'b0;
      err_o   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_addr <= addr_i;
            cnt      <= 4'(WAIT_CYCLES);
            busy_o   <= 1'b1;
            state    <= ((WAIT_CYCLES == 0) || hit) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!ce_i) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
            cnt    <= 4'd0;
          end else if (cnt <= 4'd1) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase

      // Word is captured on the edge entering RESP, so a same-edge load yields the old word.
      if (enter_resp) begin
        ready_o <= 1'b1;
        err_o   <= resp_bad;
        data_o  <= resp_bad ? '0 : resp_word;
      end

`ifdef INST_ROM_HIT_BYPASS_EN
      if (accept && hit) begin
        ready_o <= 1'b1;
        data_o  <= hit_data;
      end
      if (load_we_i && (load_addr_i == hit_idx)) hit_valid <= 1'b0;
      // A refill that coincides with a load to the same index must not be trusted.
      if (enter_resp && !resp_bad) begin
        hit_valid <= !(load_we_i && (load_addr_i == resp_idx));
        hit_idx   <= resp_idx;
        hit_data  <= resp_word;
      end
`endif
    end
  end

endmodule

// File: tb/tb_inst_rom_resp.sv
// Self-checking bench for inst_rom_resp: scoreboard of expected words and response cycles.
// Latency expectations follow INST_ROM_HIT_BYPASS_EN when that macro is defined.
module tb_inst_rom_resp;

  localparam int AW = 10;
  localparam int W  = 2;
  localparam int DW = 32;
`ifdef INST_ROM_HIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ce_i = 1'b0;
  logic [31:0]   addr_i = 32'd0;
  logic [DW-1:0] data_o;
  logic          ready_o;
  logic          err_o;
  logic          busy_o;
  logic          load_we_i = 1'b0;
  logic [AW-1:0] load_addr_i = '0;
  logic [DW-1:0] load_data_i = '0;
  logic [1:0]    state_dbg;

  inst_rom_resp #(.ADDR_W(AW), .WAIT_CYCLES(W), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i),
    .data_o(data_o), .ready_o(ready_o), .err_o(err_o), .busy_o(busy_o),
    .load_we_i(load_we_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
    .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [DW:0]   exp_q[$];
  int            cyc_q[$];
  logic [DW-1:0] mem_m [0:(1<<AW)-1];
  logic          byp_valid = 1'b0;
  logic [AW-1:0] byp_idx = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to the next falling edge and score any response seen there
  task automatic tick();
    logic [DW:0] e;
    int c;
    @(negedge clk);
    if (ready_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'(ready_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("resp_data", 64'(data_o), 64'(e[DW-1:0]));
        check("resp_err", 64'(err_o), 64'(e[DW]));
        check("resp_cycle", 64'(cyc), 64'(c));
      end
    end
  endtask

  // base = cycles from now until the accepting edge
  task automatic expect_fetch(input logic [31:0] a, input int base);
    logic          bad;
    logic [AW-1:0] idx;
    logic [DW:0]   e;
    int            lat;
    bad = (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
    idx = a[AW+1:2];
    lat = (BYP && byp_valid && !bad && (idx == byp_idx)) ? 0 : W;
    e = {bad, (bad ? {DW{1'b0}} : mem_m[idx])};
    exp_q.push_back(e);
    cyc_q.push_back(cyc + base + lat);
    if (!bad) begin
      byp_valid = 1'b1;
      byp_idx   = idx;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      check("resp_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    ce_i   = 1'b1;
    addr_i = a;
    expect_fetch(a, 1);
    drain();
    ce_i = 1'b0;
    tick();
  endtask

  task automatic load(input logic [AW-1:0] idx, input logic [DW-1:0] d);
    load_we_i   = 1'b1;
    load_addr_i = idx;
    load_data_i = d;
    tick();
    load_we_i = 1'b0;
    mem_m[idx] = d;
    if (byp_valid && (byp_idx == idx)) byp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] ridx;
    // reset
    tick();
    tick();
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    rst = 1'b1;
    tick();

    load(0, 32'h34011100);
    load(1, 32'h34020020);
    load(2, 32'h3403FF00);
    load(3, 32'h3404FFFF);

    fetch(32'h0000_0004);

    // back-to-back fetches with ce_i held high
    ce_i   = 1'b1;
    addr_i = 32'h0;
    expect_fetch(32'h0, 1);
    for (int k = 0; k < 4; k++) begin
      drain();
      check("busy_in_resp", 64'(busy_o), 64'd1);
      if (k < 3) begin
        addr_i = 32'((k + 1) * 4);
        expect_fetch(addr_i, 2);
        tick();
        check("busy_gap", 64'(busy_o), 64'd0);
      end
    end
    ce_i = 1'b0;
    tick();

    // misaligned and out-of-range addresses
    fetch(32'h0000_0002);
    fetch(32'h0000_1000);

    // abort by dropping ce_i during WAIT
    ce_i   = 1'b1;
    addr_i = 32'h0;
    tick();
    ce_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("abort_state", 64'(state_dbg), 64'd0);
    check("abort_busy", 64'(busy_o), 64'd0);
    fetch(32'h0000_0008);

    // reset during WAIT
    ce_i   = 1'b1;
    addr_i = 32'h0000_000C;
    tick();
    check("wait_busy", 64'(busy_o), 64'd1);
    rst = 1'b0;
    tick();
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_err", 64'(err_o), 64'd0);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_data", 64'(data_o), 64'd0);
    check("midrst_state", 64'(state_dbg), 64'd0);
    rst = 1'b1;
    ce_i = 1'b0;
    byp_valid = 1'b0;
    tick();
    fetch(32'h0000_000C);

    // repeat fetch, then invalidate through the load port
    fetch(32'h0000_0004);
    fetch(32'h0000_0004);
    load(1, 32'hDEADBEEF);
    fetch(32'h0000_0004);

    // randomized image and fetches over a small index range to provoke repeats
    for (int i = 0; i < 4; i++) load(AW'(16 + i), $urandom);
    for (int i = 0; i < 8; i++) begin
      ridx = AW'($urandom_range(16, 19));
      fetch({20'd0, ridx, 2'b00});
    end

    for (int i = 0; i < 4; i++) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_rom_resp.md
Name: inst_rom_resp

Overview:
- Responder end of the core's instruction-fetch port: accepts fetch requests (ce, byte address) from the core's PC stage and returns 32-bit instruction words from an internal word-addressed memory.
- Inserts a programmable number of wait states and signals completion with a one-cycle ready pulse.
- A load port lets the testbench or bootloader write program images.
- Sits beside the core top level, driven by its rom_ce_o/rom_addr_o outputs and driving its instruction data input.

Parameters:
- ADDR_W, 10, word-index width; memory depth = 2**ADDR_W words.
- WAIT_CYCLES, 2, wait states between request acceptance and the response cycle (0..15).
- DATA_W, 32, instruction word width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-low
- ce_i  in  1  fetch request enable from the core
- addr_i  in  32  fetch byte address from the core
- data_o  out  DATA_W  instruction word, valid when ready_o=1
- ready_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse with ready_o for a misaligned or out-of-range address
- busy_o  out  1  high while a request is in flight (WAIT or RESP)
- load_we_i  in  1  program-load write enable
- load_addr_i  in  ADDR_W  program-load word index
- load_data_i  in  DATA_W  program-load data

Behaviour:
- Reset (rst=0 at a clk edge):
  - FSM goes to IDLE; data_o=0, ready_o=0, err_o=0, busy_o=0; wait counter=0.
  - Memory contents are not cleared.
  - Reset while in WAIT or RESP aborts the request; no ready is produced.
- FSM states: IDLE, WAIT, RESP.
- IDLE: a request is accepted when ce_i=1 and load_we_i=0.
  - Latch addr_i into req_addr and load the counter with WAIT_CYCLES.
  - Go to WAIT, or to RESP if WAIT_CYCLES=0.
  - If load_we_i=1, no request is accepted that cycle (load has priority).
- WAIT:
  - Counter decrements each cycle; when it reaches 1, go to RESP.
  - If ce_i drops to 0: abort, return to IDLE, no ready.
  - Changes to addr_i are ignored; the latched address is used.
- RESP:
  - ready_o=1 for exactly one cycle, then IDLE.
  - data_o = mem[req_addr[ADDR_W+1:2]] (registered).
  - If req_addr[1:0]!=0 or req_addr[31:ADDR_W+2]!=0: data_o=0 and err_o=1.
- Latency: request accepted at edge T gives ready_o high in cycle T+1+WAIT_CYCLES.
  - The earliest next acceptance is the cycle after RESP.
  - Throughput is one fetch per WAIT_CYCLES+2 cycles.
- data_o holds its last value between responses; it returns to 0 only on reset.
- Load port:
  - On load_we_i=1, mem[load_addr_i] <= load_data_i at the edge, in any state.
  - A load to the index being read during RESP returns the old word (read-before-write).
- Width rules: word index = byte address >> 2; the upper address bits beyond ADDR_W+2 must be zero.

Optional Feature:
- Macro INST_ROM_HIT_BYPASS_EN.
- Defined:
  - One-entry last-fetch register holding (valid, word index, data), updated on each non-error RESP.
  - An accepted request whose word index matches a valid entry skips WAIT: RESP next cycle, data from the register, ready at T+1.
  - A load write to the matching index clears valid. Reset clears valid.
- Undefined: no register; every fetch has the full WAIT_CYCLES latency.

Test Plan:
- Load mem[0..3]=0x34011100,0x34020020,0x3403FF00,0x3404FFFF; ce_i=1, addr_i=0x00000004, WAIT_CYCLES=2 -> ready_o high exactly 3 cycles after acceptance with data_o=0x34020020, err_o=0.
- Sequential fetches 0x0,0x4,0x8,0xC with ce_i held high -> four ready pulses spaced 4 cycles apart carrying the four words in order, busy_o low for one cycle between them.
- addr_i=0x00000002 -> ready_o=1, err_o=1, data_o=0 at T+3; addr_i=0x00001000 (ADDR_W=10) -> same error response.
- ce_i dropped to 0 one cycle after acceptance -> no ready_o pulse, FSM back in IDLE; the next request at 0x8 returns 0x3403FF00.
- rst=0 asserted during WAIT -> ready_o, err_o, busy_o=0 and data_o=0 the next cycle; after release, a fetch of 0xC returns 0x3404FFFF (memory preserved).
- With INST_ROM_HIT_BYPASS_EN: fetch 0x4 twice -> second ready at T+1 with 0x34020020; load mem[1]=0xDEADBEEF then fetch 0x4 -> full latency T+3 and data 0xDEADBEEF.
